// File: rtl/mem_arb_pkg.sv
// Shared types and big-endian byte-lane helpers for mem_word_arbiter.
// Round-robin collision handling is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   // Lane 0 is the most significant byte of the word.
   function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [7:0] b);
      logic [31:0] w;
      w = word;
      case (lane)
         2'd0:    w[31:24] = b;
         2'd1:    w[23:16] = b;
         2'd2:    w[15:8]  = b;
         default: w[7:0]   = b;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mem_word_serdes.sv
// Byte sequencer for one word transfer: byte counter, wrapping address,
// write-lane select and read-lane merge.
module mem_word_serdes
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       rword_cur,
   input  logic [7:0]        rbyte,
   output logic [ADDR_W-1:0] byte_addr,
   output logic [7:0]        wbyte,
   output logic [31:0]       rword_next,
   output logic              last
);

   logic [1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = 2'd0;
      end else if (advance) begin
         cnt_d = cnt_q + 2'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Truncation to ADDR_W bits gives the wrap at the top of memory.
   assign byte_addr  = base_addr + ADDR_W'(cnt_q);
   assign wbyte      = lane_get(wdata, cnt_q);
   assign rword_next = lane_put(rword_cur, cnt_q, rbyte);
   assign last       = (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_word_arbiter.sv
// Shares a byte-wide memory between fetch and data paths, one 32-bit word per grant.
// Define MEM_ARB_RR_EN for round-robin collisions; default is data-over-fetch priority.
module mem_word_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_done,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic [31:0]       dm_rdata,
   output logic              dm_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       dm_rdata_q, dm_rdata_d;

   logic              grant_dm;
   logic              start;
   logic              in_xfer;
   logic [ADDR_W-1:0] byte_addr;
   logic [7:0]        wbyte;
   logic [31:0]       rword_cur;
   logic [31:0]       rword_next;
   logic              last;

   assign start   = (state_q == IDLE) && (if_req || dm_req);
   assign in_xfer = (state_q == XFER);

`ifdef MEM_ARB_RR_EN
   owner_t last_q, last_d;

   // Reset pointer says fetch, so the first collision after reset goes to data.
   assign grant_dm = dm_req && (!if_req || (last_q == OWN_IF));

   always_comb begin
      last_d = last_q;
      if (start) begin
         last_d = grant_dm ? OWN_DM : OWN_IF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= OWN_IF;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign grant_dm = dm_req;
`endif

   assign rword_cur = (owner_q == OWN_DM) ? dm_rdata_q : if_rdata_q;

   mem_word_serdes #(
      .ADDR_W (ADDR_W)
   ) u_serdes (
      .clk        (clk),
      .rst        (rst),
      .clear      (start),
      .advance    (in_xfer),
      .base_addr  (base_q),
      .wdata      (wdata_q),
      .rword_cur  (rword_cur),
      .rbyte      (mem_rdata),
      .byte_addr  (byte_addr),
      .wbyte      (wbyte),
      .rword_next (rword_next),
      .last       (last)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      base_d     = base_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               owner_d = grant_dm ? OWN_DM : OWN_IF;
               base_d  = grant_dm ? dm_addr : if_addr;
               we_d    = grant_dm && dm_we;
               if (grant_dm) begin
                  wdata_d = dm_wdata;
               end
               state_d = XFER;
            end
         end
         XFER: begin
            if (!we_q) begin
               if (owner_q == OWN_DM) begin
                  dm_rdata_d = rword_next;
               end else begin
                  if_rdata_d = rword_next;
               end
            end
            if (last) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: read-data registers are reset so the outputs read zero straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         base_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         base_q     <= base_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign mem_addr  = in_xfer ? byte_addr : '0;
   assign mem_we    = in_xfer && we_q;
   assign mem_wdata = (in_xfer && we_q) ? wbyte : 8'h00;
   assign busy      = (state_q != IDLE);
   assign if_done   = (state_q == DONE) && (owner_q == OWN_IF);
   assign dm_done   = (state_q == DONE) && (owner_q == OWN_DM);
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_word_arbiter.sv
// Directed bench for mem_word_arbiter with a 32-byte memory model; expected
// collision order follows MEM_ARB_RR_EN.
module tb_mem_word_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we;
   logic [4:0]  if_addr, dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] if_rdata, dm_rdata;
   logic        if_done, dm_done;
   logic [4:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;

   logic [7:0]  mem [32];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_word_arbiter #(.ADDR_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_done   (dm_done),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   assign mem_rdata = mem[mem_addr];

   // Single process owns the memory: preload, then byte writes on rising edges.
   initial begin : mem_proc
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      mem[5'h08] = 8'h8C; mem[5'h09] = 8'h22; mem[5'h0A] = 8'h00; mem[5'h0B] = 8'h04;
      mem[5'h1E] = 8'hA1; mem[5'h1F] = 8'hB2; mem[5'h00] = 8'hC3; mem[5'h01] = 8'hD4;
      mem[5'h04] = 8'h55; mem[5'h05] = 8'h55; mem[5'h06] = 8'h55; mem[5'h07] = 8'h55;
      forever begin
         @(posedge clk);
         if (mem_we) mem[mem_addr] <= mem_wdata;
      end
   end

   // One word request; records per-cycle observations for 8 cycles after driving it.
   task automatic xfer(input bit is_dm, input bit we, input logic [4:0] addr, input logic [31:0] wd,
                       output int done_at, output int we_cnt, output int n_if, output int n_dm,
                       output logic [19:0] seq);
      done_at = -1; we_cnt = 0; n_if = 0; n_dm = 0; seq = '0;
      @(negedge clk);
      if (is_dm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c <= 4) seq = {seq[14:0], mem_addr};
         if (mem_we) we_cnt++;
         if (if_done) begin n_if++; if (done_at < 0) done_at = c; end
         if (dm_done) begin n_dm++; if (done_at < 0) done_at = c; end
         if (if_done || dm_done) begin if_req = 1'b0; dm_req = 1'b0; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      #1;
      total++;
      if ({busy, if_done, dm_done, mem_we} !== 4'b0000) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0000", {busy, if_done, dm_done, mem_we});
      end
      total++;
      if ({mem_addr, mem_wdata} !== 13'h0) begin
         bad++; $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wdata});
      end
      total++;
      if ({if_rdata, dm_rdata} !== 64'h0) begin
         bad++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, dm_rdata});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fetch;
      int d, w, ni, nd;
      logic [19:0] s;
      xfer(1'b0, 1'b0, 5'h08, 32'h0, d, w, ni, nd, s);
      total++;
      if (if_rdata !== 32'h8C220004) begin
         bad++; $display("FAIL fetch_rdata: got %h want 8c220004", if_rdata);
      end
      total++;
      if (d !== 5 || ni !== 1 || nd !== 0) begin
         bad++; $display("FAIL fetch_done: got at=%0d if=%0d dm=%0d want at=5 if=1 dm=0", d, ni, nd);
      end
      total++;
      if (w !== 0) begin
         bad++; $display("FAIL fetch_we: got %0d want 0", w);
      end
      total++;
      if (s !== {5'h08, 5'h09, 5'h0A, 5'h0B}) begin
         bad++; $display("FAIL fetch_addr: got %h want %h", s, {5'h08, 5'h09, 5'h0A, 5'h0B});
      end
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL fetch_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_store;
      int d, w, ni, nd;
      logic [19:0] s;
      xfer(1'b1, 1'b1, 5'h10, 32'hDEADBEEF, d, w, ni, nd, s);
      total++;
      if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF) begin
         bad++; $display("FAIL store_mem: got %h want deadbeef", {mem[16], mem[17], mem[18], mem[19]});
      end
      total++;
      if (w !== 4) begin
         bad++; $display("FAIL store_we: got %0d want 4", w);
      end
      total++;
      if (d !== 5 || nd !== 1 || ni !== 0) begin
         bad++; $display("FAIL store_done: got at=%0d dm=%0d if=%0d want at=5 dm=1 if=0", d, nd, ni);
      end
   endtask

   task automatic test_wrap;
      int d, w, ni, nd;
      logic [19:0] s;
      xfer(1'b1, 1'b0, 5'h1E, 32'h0, d, w, ni, nd, s);
      total++;
      if (s !== {5'h1E, 5'h1F, 5'h00, 5'h01}) begin
         bad++; $display("FAIL wrap_addr: got %h want %h", s, {5'h1E, 5'h1F, 5'h00, 5'h01});
      end
      total++;
      if (dm_rdata !== 32'hA1B2C3D4) begin
         bad++; $display("FAIL wrap_rdata: got %h want a1b2c3d4", dm_rdata);
      end
      total++;
      if (w !== 0 || nd !== 1) begin
         bad++; $display("FAIL wrap_load: got we=%0d dm=%0d want we=0 dm=1", w, nd);
      end
      total++;
      if (if_rdata !== 32'h8C220004) begin
         bad++; $display("FAIL wrap_if_hold: got %h want 8c220004", if_rdata);
      end
   endtask

   task automatic test_reset_mid_store;
      int d, w, ni, nd, dn;
      logic [19:0] s;
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'h04; dm_wdata = 32'h11223344;
      repeat (3) @(negedge clk);
      total++;
      if (mem_addr !== 5'h06 || mem_we !== 1'b1) begin
         bad++; $display("FAIL rst_pre: got addr=%h we=%b want addr=06 we=1", mem_addr, mem_we);
      end
      rst = 1'b1;
      dm_req = 1'b0; dm_we = 1'b0;
      #1;
      total++;
      if ({busy, if_done, dm_done, mem_we, mem_addr, mem_wdata} !== 17'h0) begin
         bad++; $display("FAIL rst_mid_out: got %h want 0", {busy, if_done, dm_done, mem_we, mem_addr, mem_wdata});
      end
      total++;
      if ({if_rdata, dm_rdata} !== 64'h0) begin
         bad++; $display("FAIL rst_mid_rdata: got %h want 0", {if_rdata, dm_rdata});
      end
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (6) begin
         @(negedge clk);
         if (dm_done) dn++;
      end
      total++;
      if (dn !== 0) begin
         bad++; $display("FAIL rst_no_done: got %0d want 0", dn);
      end
      total++;
      if ({mem[4], mem[5], mem[6], mem[7]} !== 32'h11225555) begin
         bad++; $display("FAIL rst_partial: got %h want 11225555", {mem[4], mem[5], mem[6], mem[7]});
      end
      xfer(1'b0, 1'b0, 5'h04, 32'h0, d, w, ni, nd, s);
      total++;
      if (if_rdata !== 32'h11225555 || ni !== 1 || d !== 5) begin
         bad++; $display("FAIL rst_recover: got %h if=%0d at=%0d want 11225555 if=1 at=5", if_rdata, ni, d);
      end
   endtask

   task automatic test_collision;
      int rem_if, rem_dm, n;
      int at [4];
      logic [3:0] order, exp_order;
`ifdef MEM_ARB_RR_EN
      exp_order = 4'b0101;
`else
      exp_order = 4'b0011;
`endif
      rem_if = 2; rem_dm = 2; n = 0; order = '0;
      for (int k = 0; k < 4; k++) at[k] = -1;
      @(negedge clk);
      if_req = 1'b1; if_addr = 5'h08;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'h10;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if ((if_done || dm_done) && n < 4) begin
            order[n] = dm_done;
            at[n] = c;
            n++;
         end
         if (dm_done) begin rem_dm--; if (rem_dm <= 0) dm_req = 1'b0; end
         if (if_done) begin rem_if--; if (rem_if <= 0) if_req = 1'b0; end
      end
      if_req = 1'b0; dm_req = 1'b0;
      total++;
      if (n !== 4 || order !== exp_order) begin
         bad++; $display("FAIL coll_order: got n=%0d order=%b want n=4 order=%b", n, order, exp_order);
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (at[k] !== 5 + 6 * k) begin
            bad++; $display("FAIL coll_spacing%0d: got %0d want %0d", k, at[k], 5 + 6 * k);
         end
      end
      total++;
      if (dm_rdata !== 32'hDEADBEEF || if_rdata !== 32'h8C220004) begin
         bad++; $display("FAIL coll_rdata: got dm=%h if=%h want deadbeef 8c220004", dm_rdata, if_rdata);
      end
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_store;
      test_wrap;
      test_reset_mid_store;
      test_collision;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
